// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Transmit-side byte buffer and launch controller. Host bytes are queued in
//   a circular FIFO and handed to the UART transmitter one at a time: the
//   controller pulses tx_start with the byte on din, then waits for
//   tx_done_tick before it launches the next byte.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   wr_en         host write strobe
//   wr_data       byte to enqueue when wr_en=1
//   tx_done_tick  one-cycle pulse from the transmitter at end of stop bit
//   tx_start      one-cycle registered launch pulse to the transmitter
//   din           registered byte being launched; held until next launch
//   full          occupancy equals 2^ADDR_W
//   empty         occupancy equals 0
//   count         current occupancy, 0 .. 2^ADDR_W
//   busy          a launched byte is still in the transmitter
//   overflow      sticky; set when a write is dropped on a full FIFO
module uart_tx_fifo #(
  parameter int unsigned DBIT   = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DBIT-1:0]   wr_data,
  input  logic              tx_done_tick,
  output logic              tx_start,
  output logic [DBIT-1:0]   din,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned       DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [DBIT-1:0]    mem_q [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic               tx_start_q, tx_start_d;
  logic [DBIT-1:0]    din_q, din_d;
  logic               overflow_q, overflow_d;

  logic               full_w, empty_w;
  logic               wr_accept;
  logic               pop;

  assign full_w  = (count_q == DEPTH_CNT);
  assign empty_w = (count_q == '0);

  // A write on a full FIFO is refused even if a pop frees a slot on the
  // same edge; the full decision is made on the pre-edge occupancy.
  assign wr_accept = wr_en & ~full_w;

  // The byte leaves the FIFO at launch time, not when transmission ends.
  assign pop = (state_q == IDLE) & ~empty_w;

  // Launch FSM, read pointer and output registers.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    din_d      = din_q;
    rd_ptr_d   = rd_ptr_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d    = BUSY;
          tx_start_d = 1'b1;
          din_d      = mem_q[rd_ptr_q];
          rd_ptr_d   = rd_ptr_q + 1'b1;
        end
      end
      BUSY: begin
        if (tx_done_tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write pointer, occupancy and overflow bookkeeping.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_en & full_w);
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_start_q <= 1'b0;
      din_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_start_q <= tx_start_d;
      din_q      <= din_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array carries no reset; stale contents are never read because
  // occupancy gates every pop.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign tx_start = tx_start_q;
  assign din      = din_q;
  assign full     = full_w;
  assign empty    = empty_w;
  assign count    = count_q;
  assign busy     = (state_q == BUSY);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       man_done = 1'b0;
  logic       auto_en = 1'b0;
  logic       auto_done = 1'b0;
  logic       tx_done_tick;
  logic       tx_start;
  logic [7:0] din;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  assign tx_done_tick = auto_en ? auto_done : man_done;

  uart_tx_fifo #(.DBIT(8), .ADDR_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .din          (din),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [7:0] sb[$];
  int         mcount = 0;
  int         launches = 0;
  logic       pending = 1'b0;
  logic       m_ovf = 1'b0;
  logic       exp_ts = 1'b0;

  always begin : mon
    logic       acc, drop, dn;
    logic [7:0] wd, e;
    @(posedge clk);
    if (reset) begin
      sb.delete();
      mcount  = 0;
      pending = 1'b0;
      m_ovf   = 1'b0;
      exp_ts  = 1'b0;
    end else begin
      acc  = wr_en && (mcount < 16);
      drop = wr_en && (mcount == 16);
      dn   = tx_done_tick && pending;
      wd   = wr_data;
      #1;
      chk("sb_tx_start", {31'd0, tx_start}, {31'd0, exp_ts});
      if (dn) pending = 1'b0;
      if (acc) begin
        sb.push_back(wd);
        mcount++;
      end
      if (tx_start) begin
        launches++;
        if (sb.size() == 0) begin
          chk("sb_unexpected_launch", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_din", {24'd0, din}, {24'd0, e});
          mcount--;
        end
        pending = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      chk("sb_count",    {27'd0, count},    32'(mcount));
      chk("sb_overflow", {31'd0, overflow}, {31'd0, m_ovf});
      chk("sb_busy",     {31'd0, busy},     {31'd0, pending});
      chk("sb_empty",    {31'd0, empty},    {31'd0, (mcount == 0)});
      chk("sb_full",     {31'd0, full},     {31'd0, (mcount == 16)});
      exp_ts = !pending && (mcount > 0);
    end
  end

  // ---------------- transmitter model ----------------
  int auto_cnt = 0;
  int auto_delay = 20;

  always begin : xmit
    @(posedge clk);
    #1;
    if (reset) begin
      auto_cnt  = 0;
      auto_done = 1'b0;
    end else begin
      auto_done = 1'b0;
      if (auto_cnt != 0) begin
        auto_cnt--;
        if (auto_cnt == 1) auto_done = 1'b1;
      end
      if (tx_start && auto_en) auto_cnt = auto_delay;
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       done;
    logic [4:0] cnt;
    logic       emp;
    logic       ful;
    logic       bsy;
    logic       ts;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[16];

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (!(empty && !busy && !tx_start) && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_drain_timeout"}, 32'(n >= budget), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    int l0;

    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
    tbl[3]  = '{1'b1, 8'h3C, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
    tbl[4]  = '{1'b1, 8'h7E, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C};
    tbl[7]  = '{1'b1, 8'h11, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
    tbl[8]  = '{1'b1, 8'h22, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7E};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7E};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22};

    // Reset values and quiet interval
    @(negedge clk);
    #1;
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_din",      {24'd0, din},      32'd0);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_full",     {31'd0, full},     32'd0);
    chk("rst_empty",    {31'd0, empty},    32'd1);
    chk("rst_count",    {27'd0, count},    32'd0);
    @(negedge clk);
    reset = 1'b0;
    l0 = launches;
    repeat (100) tick();
    chk("rst_no_launch", 32'(launches - l0), 32'd0);

    // Table-driven cycle-accurate vectors (manual done pulses)
    for (int r = 0; r < 16; r++) begin
      wr_en    = tbl[r].wr;
      wr_data  = tbl[r].d;
      man_done = tbl[r].done;
      tick();
      chk($sformatf("tbl%0d_count", r),    {27'd0, count},    {27'd0, tbl[r].cnt});
      chk($sformatf("tbl%0d_empty", r),    {31'd0, empty},    {31'd0, tbl[r].emp});
      chk($sformatf("tbl%0d_full", r),     {31'd0, full},     {31'd0, tbl[r].ful});
      chk($sformatf("tbl%0d_busy", r),     {31'd0, busy},     {31'd0, tbl[r].bsy});
      chk($sformatf("tbl%0d_tx_start", r), {31'd0, tx_start}, {31'd0, tbl[r].ts});
      chk($sformatf("tbl%0d_din", r),      {24'd0, din},      {24'd0, tbl[r].dout});
    end
    wr_en    = 1'b0;
    man_done = 1'b0;

    // Burst with transmitter done 20 cycles after each launch
    auto_delay = 20;
    auto_en    = 1'b1;
    l0 = launches;
    for (int i = 1; i <= 5; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    wait_idle(300, "burst");
    chk("burst_launches", 32'(launches - l0), 32'd5);
    chk("burst_sb_empty", 32'(sb.size()), 32'd0);

    // Full and overflow with the FSM held in BUSY
    do_reset();
    auto_en = 1'b0;
    tick();
    write_byte(8'hEE);
    tick();
    chk("full_hold_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 17; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h10 + i);
      tick();
      if (i == 14) begin
        chk("full_at15_full",  {31'd0, full},  32'd0);
        chk("full_at15_count", {27'd0, count}, 32'd15);
      end
      if (i == 15) begin
        chk("full_at16_full",     {31'd0, full},     32'd1);
        chk("full_at16_count",    {27'd0, count},    32'd16);
        chk("full_at16_overflow", {31'd0, overflow}, 32'd0);
      end
      if (i == 16) begin
        chk("full_at17_count",    {27'd0, count},    32'd16);
        chk("full_at17_overflow", {31'd0, overflow}, 32'd1);
      end
    end
    wr_en    = 1'b0;
    man_done = 1'b1;
    tick();
    man_done   = 1'b0;
    auto_delay = 3;
    auto_en    = 1'b1;
    wait_idle(300, "full");
    chk("full_overflow_sticky", {31'd0, overflow}, 32'd1);
    chk("full_sb_empty", 32'(sb.size()), 32'd0);

    // Wrap-around: 40 bytes through a 16-deep FIFO
    do_reset();
    chk("wrap_overflow_cleared", {31'd0, overflow}, 32'd0);
    auto_delay = 2;
    auto_en    = 1'b1;
    l0 = launches;
    for (int i = 0; i < 40; i++) begin
      int g = 0;
      while (full && g < 100) begin
        tick();
        g++;
      end
      wr_en   = 1'b1;
      wr_data = 8'(8'h30 + i);
      tick();
      wr_en   = 1'b0;
    end
    wait_idle(500, "wrap");
    chk("wrap_launches", 32'(launches - l0), 32'd40);
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

    // Simultaneous write+pop, then reset mid-transfer
    do_reset();
    auto_en = 1'b0;
    tick();
    write_byte(8'h41);
    chk("simul_pre_count", {27'd0, count}, 32'd1);
    write_byte(8'h42);
    chk("simul_tx_start", {31'd0, tx_start}, 32'd1);
    chk("simul_count",    {27'd0, count},    32'd1);
    write_byte(8'h43);
    write_byte(8'h44);
    chk("mid_count", {27'd0, count}, 32'd3);
    chk("mid_busy",  {31'd0, busy},  32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_count",    {27'd0, count},    32'd0);
    chk("mid_rst_busy",     {31'd0, busy},     32'd0);
    chk("mid_rst_empty",    {31'd0, empty},    32'd1);
    chk("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    l0 = launches;
    man_done = 1'b1;
    repeat (50) tick();
    man_done = 1'b0;
    chk("mid_rst_no_launch", 32'(launches - l0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
